// File: rtl/car_pkg.sv
// Shared definitions for the line-following car: tracker steering codes and
// the drive-sequencing state encoding (also exported as the mode output).
package car_pkg;

    localparam logic [1:0] TRK_LEFT   = 2'b00;
    localparam logic [1:0] TRK_DIRECT = 2'b01;
    localparam logic [1:0] TRK_RIGHT  = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STRAIGHT = 3'd1,
        TURN_L   = 3'd2,
        TURN_R   = 3'd3,
        SEARCH   = 3'd4,
        HALT     = 3'd5
    } drive_state_t;

    // Code 11 has no meaning of its own and steers like direct.
    function automatic drive_state_t steer_state(input logic [1:0] trk);
        case (trk)
            TRK_LEFT:  return TURN_L;
            TRK_RIGHT: return TURN_R;
            default:   return STRAIGHT;
        endcase
    endfunction

endpackage

// File: rtl/line_follow_ctrl_if.sv
// Sensor-in / wheel-command-out bundle between the tracker, the drive
// controller (master) and the motor PWM block (slave).
interface line_follow_ctrl_if
    import car_pkg::*;
#(
    parameter int SPEED_W = 10
);
    logic [1:0]         tracker_state;
    logic               left_track;
    logic               mid_track;
    logic               right_track;
    logic [SPEED_W-1:0] left_speed;
    logic [SPEED_W-1:0] right_speed;
    logic               left_dir;
    logic               right_dir;
    drive_state_t       mode;
    logic               lost;

    modport master (
        input  tracker_state, left_track, mid_track, right_track,
        output left_speed, right_speed, left_dir, right_dir, mode, lost
    );

    modport slave (
        output tracker_state, left_track, mid_track, right_track,
        input  left_speed, right_speed, left_dir, right_dir, mode, lost
    );

endinterface

// File: rtl/line_follow_ctrl_debounce.sv
// Candidate/count debouncer: stable asserts on the edge where the sample has
// been seen DEBOUNCE times in a row, so the consumer can act on that same edge.
module track_debounce #(
    parameter int               WIDTH     = 2,
    parameter int               DEBOUNCE  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] accepted,
    output logic             stable
);
    localparam int            CW     = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE);

    logic [WIDTH-1:0] candidate;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;

    always_comb begin
        count_next = count;
        if (sample != candidate) begin
            count_next = CW'(1);
        end else if (count != DB_MAX) begin
            count_next = count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            candidate <= RESET_VAL;
            count     <= '0;
        end else begin
            candidate <= sample;
            count     <= count_next;
        end
    end

    // After this edge the candidate equals the sample, so expose the sample.
    assign stable   = (count_next == DB_MAX);
    assign accepted = sample;

endmodule

// File: rtl/line_follow_ctrl.sv
// Drive-sequencing FSM for the line-following car: debounced steering,
// lost-line detection, timed pivot search and sticky halt.
module line_follow_ctrl
    import car_pkg::*;
#(
    parameter int                 SPEED_W       = 10,
    parameter logic [SPEED_W-1:0] FAST_SPEED    = 10'd800,
    parameter logic [SPEED_W-1:0] SLOW_SPEED    = 10'd400,
    parameter logic [SPEED_W-1:0] SEARCH_SPEED  = 10'd500,
    parameter int                 DEBOUNCE      = 4,
    parameter int                 LOST_CYCLES   = 16,
    parameter int                 SEARCH_CYCLES = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    line_follow_ctrl_if.master bus
);
    localparam int            LW         = $clog2(LOST_CYCLES + 1);
    localparam int            SW         = $clog2(SEARCH_CYCLES + 1);
    localparam logic [LW-1:0] LOST_MAX   = LW'(LOST_CYCLES);
    localparam logic [SW-1:0] SEARCH_MAX = SW'(SEARCH_CYCLES);

    drive_state_t       state, state_next;
    logic               last_left, last_left_next;
    logic               lost_q, lost_next;
    logic [LW-1:0]      white_cnt, white_cnt_next, white_inc;
    logic [SW-1:0]      search_cnt, search_cnt_next, search_inc;
    logic [SPEED_W-1:0] left_speed_q, right_speed_q, left_speed_next, right_speed_next;
    logic               left_dir_q, right_dir_q, left_dir_next, right_dir_next;
    logic [1:0]         accepted;
    logic               stable;
    logic               all_white;
    logic               driving;
    logic               lost_hit;
    logic               search_hit;

    track_debounce #(
        .WIDTH     (2),
        .DEBOUNCE  (DEBOUNCE),
        .RESET_VAL (TRK_DIRECT)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .sample   (bus.tracker_state),
        .accepted (accepted),
        .stable   (stable)
    );

    // Timeouts look at the incremented count so they fire on the edge that reaches the limit.
    always_comb begin
        all_white  = !(bus.left_track || bus.mid_track || bus.right_track);
        driving    = state inside {STRAIGHT, TURN_L, TURN_R};
        white_inc  = (white_cnt == LOST_MAX) ? white_cnt : white_cnt + LW'(1);
        search_inc = (search_cnt == SEARCH_MAX) ? search_cnt : search_cnt + SW'(1);
        lost_hit   = driving && all_white && (white_inc == LOST_MAX);
        search_hit = (search_inc == SEARCH_MAX);
    end

    always_comb begin
        state_next = state;
        lost_next  = lost_q;
        if (!enable) begin
            state_next = IDLE;
            lost_next  = 1'b0;
        end else begin
            case (state)
                IDLE: state_next = STRAIGHT;
                STRAIGHT, TURN_L, TURN_R: begin
                    if (lost_hit) begin
                        state_next = SEARCH;
                    end else if (stable) begin
                        state_next = steer_state(accepted);
                    end
                end
                SEARCH: begin
                    if (!all_white) begin
                        state_next = STRAIGHT;
                    end else if (search_hit) begin
                        state_next = HALT;
                        lost_next  = 1'b1;
                    end
                end
                HALT:    state_next = HALT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        white_cnt_next = (driving && all_white && state_next != SEARCH) ? white_inc : '0;

        search_cnt_next = search_cnt;
        if (state_next == SEARCH && state != SEARCH) begin
            search_cnt_next = '0;
        end else if (state == SEARCH) begin
            search_cnt_next = search_inc;
        end

        last_left_next = last_left;
        if (state_next == TURN_L) begin
            last_left_next = 1'b1;
        end else if (state_next == TURN_R) begin
            last_left_next = 1'b0;
        end
    end

    // Wheel commands are decoded from the next state so they register alongside it.
    always_comb begin
        left_speed_next  = '0;
        right_speed_next = '0;
        left_dir_next    = 1'b1;
        right_dir_next   = 1'b1;
        case (state_next)
            STRAIGHT: begin
                left_speed_next  = FAST_SPEED;
                right_speed_next = FAST_SPEED;
            end
            TURN_L: begin
                left_speed_next  = SLOW_SPEED;
                right_speed_next = FAST_SPEED;
            end
            TURN_R: begin
                left_speed_next  = FAST_SPEED;
                right_speed_next = SLOW_SPEED;
            end
            SEARCH: begin
                left_speed_next  = SEARCH_SPEED;
                right_speed_next = SEARCH_SPEED;
                left_dir_next    = !last_left_next;
                right_dir_next   = last_left_next;
            end
            default: begin
                left_speed_next  = '0;
                right_speed_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            last_left     <= 1'b1;
            lost_q        <= 1'b0;
            white_cnt     <= '0;
            search_cnt    <= '0;
            left_speed_q  <= '0;
            right_speed_q <= '0;
            left_dir_q    <= 1'b1;
            right_dir_q   <= 1'b1;
        end else begin
            state         <= state_next;
            last_left     <= last_left_next;
            lost_q        <= lost_next;
            white_cnt     <= white_cnt_next;
            search_cnt    <= search_cnt_next;
            left_speed_q  <= left_speed_next;
            right_speed_q <= right_speed_next;
            left_dir_q    <= left_dir_next;
            right_dir_q   <= right_dir_next;
        end
    end

    assign bus.mode        = state;
    assign bus.lost        = lost_q;
    assign bus.left_speed  = left_speed_q;
    assign bus.right_speed = right_speed_q;
    assign bus.left_dir    = left_dir_q;
    assign bus.right_dir   = right_dir_q;

endmodule

// File: doc/line_follow_ctrl.md
# line_follow_ctrl

Drive-sequencing controller for the line-following car. Consumes the 2-bit steering decision from the tracker sensor block plus the three raw track bits. Produces per-wheel speed and direction commands for the motor PWM block. Debounces steering changes, detects a lost line, runs a timed pivot search toward the last turn direction, and halts with a sticky `lost` flag if the line is not reacquired.

## Interface
- `SPEED_W`, 10: width of the speed command.
- `FAST_SPEED`, 10'd800: outer-wheel and straight speed.
- `SLOW_SPEED`, 10'd400: inner-wheel speed during a turn.
- `SEARCH_SPEED`, 10'd500: pivot speed during a search.
- `DEBOUNCE`, 4: consecutive equal `tracker_state` samples required before the controller acts on them (≥1).
- `LOST_CYCLES`, 16: consecutive all-white cycles that declare the line lost (≥1).
- `SEARCH_CYCLES`, 256: maximum search duration before halting (≥1).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `enable` in 1: run request; low forces IDLE.
- `tracker_state` in 2: 00 left, 01 direct, 10 right; 11 is treated as direct.
- `left_track`, `mid_track`, `right_track` in 1 each: raw sensors, 1 = black.
- `left_speed`, `right_speed` out SPEED_W: wheel speed commands.
- `left_dir`, `right_dir` out 1: 1 = forward, 0 = reverse.
- `mode` out 3: current FSM state.
- `lost` out 1: sticky line-lost flag.

## Operation
- States: IDLE=0, STRAIGHT=1, TURN_L=2, TURN_R=3, SEARCH=4, HALT=5.
- Outputs per state:
  - IDLE and HALT: speeds 0, dirs 1.
  - STRAIGHT: FAST/FAST, both forward.
  - TURN_L: left SLOW, right FAST.
  - TURN_R: left FAST, right SLOW.
  - SEARCH: pivot toward `last_turn`. Left pivot: left wheel SEARCH_SPEED reverse, right wheel SEARCH_SPEED forward. Right pivot is mirrored.
- Debounce:
  - A candidate register and a count track `tracker_state`.
  - When the sample differs from the candidate, load the candidate and set count=1.
  - When the sample matches, count saturates at DEBOUNCE.
  - `stable` = count reaches DEBOUNCE. The accepted value is the candidate.
- Transitions, in priority order:
  1. `enable`=0: go to IDLE from any state and clear `lost`.
  2. IDLE with `enable`=1: go to STRAIGHT.
  3. In STRAIGHT, TURN_L or TURN_R: if the all-white counter reaches LOST_CYCLES, go to SEARCH. Otherwise, if `stable`, go to the state matching the accepted value: 00 gives TURN_L, 10 gives TURN_R, 01 or 11 gives STRAIGHT.
  4. SEARCH: any raw track = 1 gives STRAIGHT. Otherwise, when the search counter reaches SEARCH_CYCLES, go to HALT and set `lost`=1.
  5. HALT: stay until `enable`=0.
- `last_turn`:
  - Updated on entry to TURN_L (left) or TURN_R (right).
  - Reset value is left.
  - Not cleared by IDLE.
- All-white counter:
  - Increments while all three tracks are 0 and the FSM is in STRAIGHT, TURN_L or TURN_R.
  - Clears otherwise, and on entry to SEARCH.
- Search counter: clears on entry to SEARCH and increments each SEARCH cycle.
- Counters saturate, never wrap. Widths are `$clog2(max+1)`.

## Timing
- `mode`, speeds, dirs and `lost` are all registered. They update on the same edge as the state transition.
- Reset (`reset`=0 at an edge) sets:
  - `mode`=IDLE, speeds 0, dirs 1, `lost`=0;
  - all counters 0, candidate=01, `last_turn`=left.
- Reset mid-operation has the same effect.
- Steering latency: a new `tracker_state` held from cycle k first takes effect at the DEBOUNCE-th rising edge sampling it.
- Lost latency: all-white first sampled at edge j produces SEARCH at edge j+LOST_CYCLES-1.
- Simultaneous events:
  - Lost timeout together with debounce acceptance: SEARCH wins.
  - Reacquire together with search timeout: STRAIGHT wins.
  - `enable`=0 overrides everything.
- IDLE to STRAIGHT takes one edge after `enable` rises.

## Structure
- Shared package `car_pkg` holds:
  - tracker codes TRK_LEFT/TRK_DIRECT/TRK_RIGHT;
  - the `drive_state_t` enum, also used for the `mode` encoding.
- The tracker sensor block imports the tracker codes from `car_pkg`.
- Sub-module `track_debounce`, parameterised by width and DEBOUNCE, provides the candidate, count and `stable` logic.
- Counters and the FSM live in the top module.

## Test plan
Defaults apply unless a scenario states otherwise.
1. Reset with `enable`=1, then release → IDLE for one edge, then STRAIGHT with speeds 800/800, dirs 1/1, `lost`=0.
2. `tracker_state`=00 held 3 cycles, then 01 → no change from STRAIGHT. Hold 00 for 4 cycles → TURN_L on the 4th edge, speeds 400/800.
3. From TURN_R, all tracks 0 for 16 cycles → SEARCH on the 16th edge with left 500 forward and right 500 reverse. Set `mid_track`=1 → STRAIGHT on the next edge.
4. SEARCH with tracks held 0 → HALT after 256 cycles, speeds 0, `lost`=1. `enable` low → IDLE with `lost`=0.
5. Debounce acceptance of 10 on the same edge as the lost timeout → SEARCH. Then `enable`=0 mid-search → IDLE on the next edge.
6. Assert `reset`=0 for one cycle during TURN_L → all outputs at reset values. `last_turn` returns to left, verified by a subsequent search pivoting left.
